// File: rtl/mini_alu_pkg.sv
// Shared definitions for the serial add/subtract ALU: op encodings, FSM states
// and small decode helpers used by the datapath.
package mini_alu_pkg;

  localparam logic [1:0] OP_ADD      = 2'b00;
  localparam logic [1:0] OP_SUB_ABS  = 2'b01;
  localparam logic [1:0] OP_SUB_WRAP = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    NEG  = 2'b10,
    DONE = 2'b11
  } state_t;

  // Encoding 2'b11 is an alias of SUB_WRAP, so anything other than ADD subtracts.
  function automatic logic is_sub_op(input logic [1:0] op);
    return (op != OP_ADD);
  endfunction

  function automatic logic is_abs_op(input logic [1:0] op);
    return (op == OP_SUB_ABS);
  endfunction

endpackage

// File: rtl/mini_alu_chunk_adder.sv
// CHUNK-bit combinational ripple-carry adder; one slice of the serial datapath.
module mini_alu_chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic c;

  always_comb begin
    sum = '0;
    c   = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/mini_alu_addsub_serial.sv
// Serial add/subtract ALU: processes CHUNK bits per cycle LSB first, with an
// optional negate pass for absolute-difference, and a valid/ready result port.
module mini_alu_addsub_serial
  import mini_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             neg,
  output logic             zero
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  generate
    if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_cfg
      $error("mini_alu_addsub_serial: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [1:0]       op_reg;
  logic [IDX_W-1:0] idx;
  logic             carry;

  logic             sub_op;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] sum_chunk;
  logic             chunk_cout;
  logic [WIDTH-1:0] next_result;
  logic [WIDTH-1:0] neg_result;

  // Operands are shifted right each CALC cycle, so the live chunk is always
  // the low CHUNK bits; subtraction feeds the inverted subtrahend.
  always_comb begin
    sub_op  = is_sub_op(op_reg);
    a_chunk = a_reg[CHUNK-1:0];
    b_chunk = sub_op ? ~b_reg[CHUNK-1:0] : b_reg[CHUNK-1:0];
  end

  mini_alu_chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry),
    .sum  (sum_chunk),
    .cout (chunk_cout)
  );

  // Sum chunks enter at the top and migrate down; after N cycles chunk 0 sits at the LSBs.
  always_comb begin
    next_result = (result >> CHUNK) | (WIDTH'(sum_chunk) << (WIDTH - CHUNK));
    neg_result  = (~result) + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      neg       <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= data0;
            b_reg    <= data1;
            op_reg   <= op;
            idx      <= '0;
            carry    <= is_sub_op(op);
            result   <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end

        CALC: begin
          a_reg  <= a_reg >> CHUNK;
          b_reg  <= b_reg >> CHUNK;
          result <= next_result;
          carry  <= chunk_cout;
          idx    <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            cout <= chunk_cout;
            neg  <= sub_op & ~chunk_cout;
            zero <= (next_result == '0);
            // A borrow on absolute-difference means the wrapped result must be negated.
            if (is_abs_op(op_reg) && !chunk_cout) begin
              state <= NEG;
            end else begin
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end

        NEG: begin
          result    <= neg_result;
          zero      <= (neg_result == '0);
          out_valid <= 1'b1;
          state     <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mini_alu_addsub_serial.sv
// Scoreboard bench for mini_alu_addsub_serial: directed corner cases plus
// random traffic, compared against an arithmetic reference model.
module tb_mini_alu_addsub_serial;
  import mini_alu_pkg::*;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             neg;
  logic             zero;

  typedef struct {
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             neg;
    logic             zero;
    int               lat;
    int               accept_cycle;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  bit   hold_ready = 1'b0;
  bit   prev_valid = 1'b0;

  mini_alu_addsub_serial #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .data0     (data0),
    .data1     (data1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .neg       (neg),
    .zero      (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: plain unsigned arithmetic on the full operands.
  function automatic exp_t refModel(input logic [1:0] o, input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b);
    exp_t e;
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint unsigned s;
    if (o == OP_ADD) begin
      s        = ua + ub;
      e.result = WIDTH'(s);
      e.cout   = (s >= (64'd1 << WIDTH));
      e.neg    = 1'b0;
      e.lat    = N;
    end else begin
      e.cout = (ua >= ub);
      e.neg  = (ua < ub);
      if (o == OP_SUB_ABS) e.result = (ua >= ub) ? WIDTH'(ua - ub) : WIDTH'(ub - ua);
      else                 e.result = WIDTH'(ua - ub);
      e.lat  = ((o == OP_SUB_ABS) && (ua < ub)) ? N + 1 : N;
    end
    e.zero         = (e.result == '0);
    e.accept_cycle = 0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got timeout, expected event", name);
  endtask

  task automatic applyStimulus(input logic [1:0] o, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b);
    exp_t e;
    int   waited = 0;
    bit   accepted = 1'b0;
    e = refModel(o, a, b);
    @(posedge clk); #1;
    in_valid = 1'b1;
    op       = o;
    data0    = a;
    data1    = b;
    while (!accepted && waited < 200) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        e.accept_cycle = cycle + 1;
        exp_q.push_back(e);
        accepted = 1'b1;
      end else begin
        waited++;
      end
    end
    if (!accepted) timeoutFail("accept");
    @(posedge clk); #1;
    in_valid = 1'b0;
    op       = 2'($urandom);
    data0    = WIDTH'($urandom);
    data1    = WIDTH'($urandom);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) timeoutFail("drain");
  endtask

  task automatic waitValid();
    int n = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (out_valid !== 1'b1) timeoutFail("wait_out_valid");
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops one expectation per handshake and checks hold stability every DONE cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev_valid = 1'b0;
      end else begin
        if (out_valid === 1'b1) begin
          checkOutput("in_ready_in_done", 32'(in_ready), 32'(0));
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_out_valid: got out_valid=1, expected 0");
          end else begin
            if (!prev_valid)
              checkOutput("latency", 32'(cycle - exp_q[0].accept_cycle), 32'(exp_q[0].lat));
            checkOutput("result", 32'(result), 32'(exp_q[0].result));
            checkOutput("cout", 32'(cout), 32'(exp_q[0].cout));
            checkOutput("neg", 32'(neg), 32'(exp_q[0].neg));
            checkOutput("zero", 32'(zero), 32'(exp_q[0].zero));
            if (out_ready === 1'b1) void'(exp_q.pop_front());
          end
        end
        prev_valid = (out_valid === 1'b1);
      end
    end
  end

  initial begin
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    op       = '0;
    data0    = '0;
    data1    = '0;
    out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready", 32'(in_ready), 32'(1));
    checkOutput("reset_out_valid", 32'(out_valid), 32'(0));
    checkOutput("reset_result", 32'(result), 32'(0));
    checkOutput("reset_flags", 32'({cout, neg, zero}), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] directed corner cases");
    applyStimulus(OP_ADD,      16'hFFFF, 16'h0001);
    applyStimulus(OP_SUB_ABS,  16'h0005, 16'h0009);
    applyStimulus(OP_SUB_ABS,  16'h1234, 16'h1234);
    applyStimulus(OP_SUB_WRAP, 16'h0000, 16'h0001);
    applyStimulus(2'b11,       16'h0010, 16'h0020);
    waitDrain();

    $display("[TB] backpressure with ignored inputs in DONE");
    hold_ready = 1'b1;
    applyStimulus(OP_SUB_WRAP, 16'hABCD, 16'h1234);
    waitValid();
    repeat (3) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      op       = 2'($urandom);
      data0    = WIDTH'($urandom);
      data1    = WIDTH'($urandom);
    end
    @(posedge clk); #1;
    in_valid   = 1'b0;
    hold_ready = 1'b0;
    applyStimulus(OP_SUB_ABS, 16'h0100, 16'h0FFF);
    waitDrain();

    $display("[TB] reset during CALC");
    applyStimulus(OP_ADD, 16'h1234, 16'h1111);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("abort_in_ready", 32'(in_ready), 32'(1));
    checkOutput("abort_out_valid", 32'(out_valid), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      checkOutput("abort_no_valid", 32'(out_valid), 32'(0));
    end
    applyStimulus(OP_ADD, 16'h00FF, 16'h0001);
    waitDrain();

    $display("[TB] random traffic");
    repeat (150) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = WIDTH'($urandom);
      r_b  = WIDTH'($urandom);
      if ($urandom_range(0, 7) == 0) r_b = r_a;
      if ($urandom_range(0, 7) == 0) r_a = '0;
      applyStimulus(r_op, r_a, r_b);
    end
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
